// File: rtl/crc8_pkg.sv
// rtl/crc8_pkg.sv - shared CRC-8 types, defaults and bit-step function
package crc8_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } crc8_state_e;

  localparam logic [7:0] CRC8_POLY_DEFAULT = 8'h07;
  localparam logic [7:0] CRC8_INIT_DEFAULT = 8'h00;

  // One MSB-first LFSR step; also used by the transmit-side generator.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                           input logic       din,
                                           input logic [7:0] poly);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? poly : 8'h00);
  endfunction

endpackage

// File: rtl/crc8_lfsr_bit.sv
// rtl/crc8_lfsr_bit.sv - bit-serial CRC-8 LFSR register
module crc8_lfsr_bit
  import crc8_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY_DEFAULT,
  parameter logic [7:0] INIT = CRC8_INIT_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       shift_i,
  input  logic       in_i,
  output logic [7:0] out_o
);

  logic [7:0] crc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      crc_q <= INIT;
    end else if (shift_i) begin
      crc_q <= crc8_step(crc_q, in_i, POLY);
    end
  end

  assign out_o = crc_q;

endmodule

// File: rtl/crc8_frame_check.sv
// rtl/crc8_frame_check.sv - receive-side CRC-8 frame checker
module crc8_frame_check
  import crc8_pkg::*;
#(
  parameter logic [7:0] POLY  = CRC8_POLY_DEFAULT,
  parameter logic [7:0] INIT  = CRC8_INIT_DEFAULT,
  parameter int         LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic [7:0]       in_data_i,
  input  logic             in_valid_i,
  input  logic             in_last_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [7:0]       out_crc_o,
  output logic             out_pass_o,
  output logic [LEN_W-1:0] out_len_o
);

  crc8_state_e      state_q;
  logic [7:0]       sr_q;
  logic [2:0]       cnt_q;
  logic             last_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_d;
  logic [7:0]       crc_q;
  logic [7:0]       crc_d;
  logic             out_valid_q;
  logic [7:0]       out_crc_q;
  logic             out_pass_q;
  logic [LEN_W-1:0] out_len_q;

  crc8_lfsr_bit #(.POLY(POLY), .INIT(INIT)) u_lfsr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (clr_i || (state_q == ST_DONE)),
    .shift_i(state_q == ST_SHIFT),
    .in_i   (sr_q[7]),
    .out_o  (crc_q)
  );

  // Remainder the LFSR will hold after the current shift; captured on entry to DONE.
  assign crc_d = crc8_step(crc_q, sr_q[7], POLY);
  assign len_d = (&len_q) ? len_q : len_q + LEN_W'(1);

  assign in_ready_o = (state_q == ST_IDLE) && !clr_i && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      sr_q        <= 8'h00;
      cnt_q       <= 3'd0;
      last_q      <= 1'b0;
      len_q       <= '0;
      out_valid_q <= 1'b0;
      out_crc_q   <= 8'h00;
      out_pass_q  <= 1'b0;
      out_len_q   <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (clr_i) begin
        state_q <= ST_IDLE;
        len_q   <= '0;
        last_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (in_valid_i) begin
              sr_q    <= in_data_i;
              last_q  <= in_last_i;
              len_q   <= len_d;
              cnt_q   <= 3'd7;
              state_q <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            sr_q  <= {sr_q[6:0], 1'b0};
            cnt_q <= cnt_q - 3'd1;
            if (cnt_q == 3'd0) begin
              if (last_q) begin
                state_q     <= ST_DONE;
                out_valid_q <= 1'b1;
                out_crc_q   <= crc_d;
                out_pass_q  <= (crc_d == 8'h00);
                out_len_q   <= len_q;
              end else begin
                state_q <= ST_IDLE;
              end
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            last_q  <= 1'b0;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_crc_o   = out_crc_q;
  assign out_pass_o  = out_pass_q;
  assign out_len_o   = out_len_q;

endmodule

// File: tb/tb_crc8_frame_check.sv
// tb/tb_crc8_frame_check.sv - self-checking bench for crc8_frame_check
module tb_crc8_frame_check;

  localparam logic [7:0] POLY = 8'h07;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, in_last;
  logic [7:0]  in_data;
  logic        in_ready, out_valid, out_pass;
  logic [7:0]  out_crc;
  logic [15:0] out_len;
  logic        s_ready, s_valid, s_pass;
  logic [7:0]  s_crc;
  logic [2:0]  s_len;

  always #5 clk = ~clk;

  crc8_frame_check u_dut (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_last_i(in_last), .in_ready_o(in_ready), .out_valid_o(out_valid),
    .out_crc_o(out_crc), .out_pass_o(out_pass), .out_len_o(out_len)
  );

  // Narrow length counter so saturation is reachable with short frames.
  crc8_frame_check #(.LEN_W(3)) u_sat (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_last_i(in_last), .in_ready_o(s_ready), .out_valid_o(s_valid),
    .out_crc_o(s_crc), .out_pass_o(s_pass), .out_len_o(s_len)
  );

  typedef struct {
    logic [7:0]  crc;
    logic        pass;
    logic [15:0] len;
    logic [2:0]  slen;
    int          cyc;
  } res_t;

  typedef struct {
    int         n;
    logic [7:0] b [10];
    logic [7:0] crc;
    logic       pass;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_acc = 0;
  bit         log_en = 0;
  bit         rdy_log[$];
  res_t       res_q[$];
  logic [7:0] tx_d[$];
  bit         tx_l[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) res_q.push_back('{out_crc, out_pass, out_len, s_len, cyc});
    if (log_en) rdy_log.push_back(in_ready);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Remainder of message(x)*x^8 divided by x^8+POLY, by plain long division.
  function automatic logic [7:0] model_crc(input logic [7:0] m[$]);
    logic [8:0] rem;
    rem = 9'h000;
    for (int i = 0; i < m.size() + 1; i++) begin
      for (int k = 7; k >= 0; k--) begin
        rem = {rem[7:0], (i < m.size()) ? m[i][k] : 1'b0};
        if (rem[8]) rem = rem ^ {1'b1, POLY};
      end
    end
    return rem[7:0];
  endfunction

  task automatic drive(input bit gaps);
    for (int i = 0; i < tx_d.size(); i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        in_valid = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
      end
      in_data  = tx_d[i];
      in_last  = tx_l[i];
      in_valid = 1'b1;
      begin
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 40) begin w++; @(negedge clk); end
        if (!in_ready) begin
          checks++; errors++;
          $display("FAIL accept_timeout actual=0 required=1");
          in_valid = 1'b0;
          return;
        end
      end
      @(posedge clk); #1;
      last_acc = cyc;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_results(input int n);
    int w;
    w = 0;
    while (res_q.size() < n && w < 80) begin @(negedge clk); w++; end
    repeat (2) @(negedge clk);
    chk("result_count", 32'(res_q.size()), 32'(n));
    @(posedge clk); #1;
  endtask

  task automatic check_result(input string nm, input logic [7:0] crc, input logic pass,
                              input int len, input bit chk_lat);
    res_t r;
    if (res_q.size() == 0) return;
    r = res_q.pop_front();
    chk({nm, "_crc"}, 32'(r.crc), 32'(crc));
    chk({nm, "_pass"}, 32'(r.pass), 32'(pass));
    chk({nm, "_len"}, 32'(r.len), 32'(len));
    chk({nm, "_satlen"}, 32'(r.slen), 32'((len > 7) ? 7 : len));
    if (chk_lat) chk({nm, "_latency"}, 32'(r.cyc - last_acc), 32'd8);
  endtask

  task automatic push_frame(input logic [7:0] m[$]);
    foreach (m[i]) begin
      tx_d.push_back(m[i]);
      tx_l.push_back(i == m.size() - 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vt[4];
    logic [7:0] good[$];
    logic [7:0] m[$];
    bit         exp_rdy[$];
    int         mism;

    good = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};
    for (int i = 0; i < 4; i++) for (int j = 0; j < 10; j++) vt[i].b[j] = 8'h00;
    for (int j = 0; j < 10; j++) begin vt[0].b[j] = good[j]; vt[1].b[j] = good[j]; end
    vt[0].n = 10; vt[0].crc = 8'h00; vt[0].pass = 1'b1;
    vt[1].n = 10; vt[1].b[9] = 8'hF5; vt[1].crc = 8'h07; vt[1].pass = 1'b0;
    vt[2].n = 1;  vt[2].b[0] = 8'h00; vt[2].crc = 8'h00; vt[2].pass = 1'b1;
    vt[3].n = 1;  vt[3].b[0] = 8'h01; vt[3].crc = 8'h07; vt[3].pass = 1'b0;

    // Reset held with a byte offered: nothing accepted, outputs zero.
    rst = 1'b1; clr = 1'b0; in_valid = 1'b1; in_data = 8'hA5; in_last = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_ready", 32'(in_ready), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_crc", 32'(out_crc), 32'd0);
      chk("rst_pass", 32'(out_pass), 32'd0);
      chk("rst_len", 32'(out_len), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    for (int v = 0; v < 4; v++) begin
      tx_d.delete(); tx_l.delete();
      for (int j = 0; j < vt[v].n; j++) begin
        tx_d.push_back(vt[v].b[j]);
        tx_l.push_back(j == vt[v].n - 1);
      end
      drive(1'b0);
      wait_results(1);
      check_result($sformatf("vec%0d", v), vt[v].crc, vt[v].pass, vt[v].n, 1'b1);
    end

    // Abort during the shift of byte 3, then a full good frame.
    tx_d = '{8'h31, 8'h32, 8'h33}; tx_l = '{0, 0, 0};
    drive(1'b0);
    repeat (3) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    tx_d.delete(); tx_l.delete();
    push_frame(good);
    drive(1'b0);
    wait_results(1);
    check_result("abort", 8'h00, 1'b1, 10, 1'b1);

    // clr with a byte offered in IDLE: refused and not counted.
    clr = 1'b1; in_valid = 1'b1; in_data = 8'h55; in_last = 1'b1;
    @(negedge clk);
    chk("clr_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1 clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("clr_not_accepted", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    tx_d = '{8'h01}; tx_l = '{1};
    drive(1'b0);
    wait_results(1);
    check_result("after_clr", 8'h07, 1'b0, 1, 1'b1);

    // Back-to-back frames with in_valid held high.
    tx_d.delete(); tx_l.delete();
    push_frame(good); push_frame(good);
    rdy_log.delete();
    log_en = 1'b1;
    drive(1'b0);
    wait_results(2);
    log_en = 1'b0;
    check_result("b2b_0", 8'h00, 1'b1, 10, 1'b0);
    check_result("b2b_1", 8'h00, 1'b1, 10, 1'b1);
    for (int f = 0; f < 2; f++) for (int b = 0; b < 10; b++) begin
      exp_rdy.push_back(1'b1);
      repeat (8) exp_rdy.push_back(1'b0);
      if (b == 9) exp_rdy.push_back(1'b0);
    end
    chk("rdy_log_size", 32'(rdy_log.size() >= exp_rdy.size()), 32'd1);
    mism = 0;
    for (int i = 0; i < exp_rdy.size() && i < rdy_log.size(); i++)
      if (rdy_log[i] != exp_rdy[i]) mism++;
    chk("rdy_pattern", 32'(mism), 32'd0);

    // Random frames against the long-division model, about half with a valid CRC appended.
    for (int t = 0; t < 40; t++) begin
      int n;
      logic [7:0] exp_crc;
      n = $urandom_range(1, 7);
      m.delete();
      for (int j = 0; j < n; j++) m.push_back(8'($urandom));
      if ($urandom_range(0, 1) == 1) m.push_back(model_crc(m));
      exp_crc = model_crc(m);
      tx_d.delete(); tx_l.delete();
      push_frame(m);
      drive(1'b1);
      wait_results(1);
      check_result($sformatf("rnd%0d", t), exp_crc, exp_crc == 8'h00, m.size(), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc8_frame_check.md
# crc8_frame_check

Receive-side CRC-8 frame checker. Accepts a byte stream over a valid/ready handshake, with each frame's last byte being the transmitted CRC. Each byte is serialised MSB-first through a bit-serial CRC-8 LFSR, one bit per clock. At frame end the block reports the residual remainder, a pass/fail flag and the frame length. It sits downstream of the byte source (UART/FIFO) and upstream of the packet consumer, which discards frames flagged as failed.

## Interface
- `POLY`, default 8'h07: generator polynomial, implicit x^8.
- `INIT`, default 8'h00: LFSR value at frame start and after `clr`/`rst`.
- `LEN_W`, default 16: width of the frame byte counter.
- `clk`  in  1: sole clock; all state changes on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `clr`  in  1: synchronous frame abort.
- `in_data`  in  8: byte payload.
- `in_valid`  in  1: `in_data`/`in_last` valid.
- `in_last`  in  1: this byte is the frame's CRC byte, i.e. the final byte.
- `in_ready`  out  1: block can accept a byte this cycle.
- `out_valid`  out  1: one-cycle pulse; result fields updated.
- `out_crc`  out  8: remainder after all frame bytes, including the CRC byte.
- `out_pass`  out  1: `out_crc == 8'h00`.
- `out_len`  out  LEN_W: bytes accepted in the frame, including the CRC byte; saturates at all-ones.

## Operation
- **States**
  - IDLE: `in_ready=1`.
  - SHIFT: 8 cycles, `in_ready=0`.
  - DONE: 1 cycle, `out_valid=1`, `in_ready=0`.
- **Acceptance**
  - A byte is accepted on an edge where `in_valid && in_ready`.
  - On acceptance: byte → shift register, `in_last` → `last_q`, len += 1 (saturating), bit counter = 7, state → SHIFT.
- **SHIFT cycle**
  - `b = sr[7]`; `fb = crc[7]^b`.
  - `crc <= {crc[6:0],1'b0} ^ (fb ? POLY : 8'h00)`.
  - `sr <= {sr[6:0],1'b0}`; counter decrements.
  - When counter==0: go to DONE if `last_q`, else IDLE.
- **DONE → IDLE** on the next edge.
  - On entry to DONE: register `out_crc`, `out_pass` and `out_len` from the final values.
  - On the DONE→IDLE edge: reset `crc` to `INIT` and `len` to 0.
- **Result fields**: hold until the next DONE or `rst`. `clr` does not alter them.
- **`in_ready`** = (state==IDLE) && !`clr` && !`rst`. It is combinational, so a byte is never accepted and then dropped.
- **`clr`** (when `rst` is low), from any state:
  - Next state IDLE; `crc=INIT`, `len=0`, `last_q=0`.
  - The aborted frame produces no `out_valid`.
  - `clr` asserted in the DONE cycle does not retract the already-visible pulse.
- **`rst`** has priority over `clr`. It forces IDLE, `crc=INIT`, `len=0`, and `out_valid=0`, `out_crc=0`, `out_pass=0`, `out_len=0`.
- **Length saturation**: no error flag; `out_len` stays all-ones.
- **Single-byte frame** (`in_last` on the first byte) is legal, with no special case.

## Timing
- **Reset values**: `in_ready=0` while `rst` is high, 1 on the first cycle after. All other outputs are 0.
- **Throughput**: one byte per 9 cycles (accept + 8 SHIFT) with `in_valid` held high.
- **Latency**: last byte accepted at edge N → `out_valid` high for exactly the cycle following edge N+8. Next acceptance is possible at edge N+10 at the earliest.
- **Bit order**: MSB-first; no input/output reflection; no final XOR.

## Structure
- **Package `crc8_pkg`**:
  - state enum (IDLE/SHIFT/DONE)
  - `CRC8_POLY_DEFAULT=8'h07`, `CRC8_INIT_DEFAULT=8'h00`
  - `crc8_step(crc, bit, poly)` function, shared with the transmit-side generator.
- **Sub-module `crc8_lfsr_bit`**: 8-bit LFSR register with `shift`, `clr`, serial `in`, parallel `out`, parameterised `POLY`/`INIT`.
- **Top level**: FSM, byte shift register, bit counter, length counter and result registers.

## Test plan
- **Reset**: hold `rst` 2 cycles with `in_valid=1` → no acceptance; all outputs 0. Cycle after release → `in_ready=1`.
- **Good frame**: 0x31..0x39 ("123456789") then 0xF4 with `in_last` → single `out_valid` pulse 8 cycles after the last accept; `out_crc=0x00`, `out_pass=1`, `out_len=10`.
- **Corrupted CRC**: same frame with last byte 0xF5 → `out_crc=0x07`, `out_pass=0`, `out_len=10`.
- **Single-byte frames**: 0x00 → crc 0x00, pass, len 1. 0x01 → crc 0x07, fail, len 1.
- **Abort then frame**: `clr` during SHIFT of byte 3 of a frame, then a full good frame → only one `out_valid`, with `out_len=10`, pass. `clr` coincident with `in_valid` in IDLE → `in_ready=0`, byte not counted.
- **Back-to-back**: `in_valid` held high across two good frames → `in_ready` pattern 1,0×8 per byte, plus a 0 in each DONE cycle. Two pulses, each pass; the second frame's length is independent of the first.
